// File: rtl/seq_mul_if.sv
// seq_mul_if: start/done handshake and operand/result bus of the sequential multiplier
interface seq_mul_if #(parameter int WIDTH = 8);
  logic             start;
  logic             in_signed;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;
  logic             ovf;
  modport master (output start, in_signed, in_a, in_b, input busy, done, out_lo, out_hi, ovf);
  modport slave (input start, in_signed, in_a, in_b, output busy, done, out_lo, out_hi, ovf);
endinterface

// File: rtl/seq_mul.sv
// seq_mul: iterative shift-add multiplier, one multiplier bit per cycle, signed via magnitudes
module seq_mul #(
  parameter int WIDTH = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic      clk,
  input logic      reset,
  seq_mul_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [5:0]         cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;
  logic               sgn_q;
  logic               sgn, sa, sb;
  logic [WIDTH-1:0]   ma, mb;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_d, prod_d;
  always_comb begin
    sgn    = SIGNED_EN && bus.in_signed;
    sa     = sgn && bus.in_a[WIDTH-1];
    sb     = sgn && bus.in_b[WIDTH-1];
    ma     = sa ? -bus.in_a : bus.in_a;
    mb     = sb ? -bus.in_b : bus.in_b;
    // upper half plus multiplicand keeps its carry in sum[WIDTH] before the right shift
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_d  = {sum, acc_q[WIDTH-1:1]};
    prod_d = neg_q ? -acc_d : acc_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      sgn_q      <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.out_lo <= '0;
      bus.out_hi <= '0;
      bus.ovf    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state_q == RUN) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH - 1)) begin
          state_q    <= DONE;
          bus.busy   <= 1'b0;
          bus.done   <= 1'b1;
          bus.out_lo <= prod_d[WIDTH-1:0];
          bus.out_hi <= prod_d[2*WIDTH-1:WIDTH];
          bus.ovf    <= sgn_q ? (prod_d[2*WIDTH-1:WIDTH] != {WIDTH{prod_d[WIDTH-1]}})
                              : (prod_d[2*WIDTH-1:WIDTH] != '0);
        end
      end else if (bus.start) begin
        state_q  <= RUN;
        cnt_q    <= '0;
        a_q      <= ma;
        acc_q    <= {{WIDTH{1'b0}}, mb};
        neg_q    <= sa ^ sb;
        sgn_q    <= sgn;
        bus.busy <= 1'b1;
      end else begin
        state_q <= IDLE;
      end
    end
  end
endmodule
